// File: rtl/shop_cmd_ctrl_if.sv
// Command/response and database handshake bundle for shop_cmd_ctrl.
// The slave modport is the controller; the master modport is the command
// source together with the item database it talks to.
interface shop_cmd_ctrl_if #(
    parameter int I_A_NUM_BITS = 24,
    parameter int I_U_NUM_BITS = 4,
    parameter int O_A_NUM_BITS = 24
);
    logic                    i_rdy;
    logic [2:0]              i_cmd;
    logic [I_U_NUM_BITS-1:0] i_u;
    logic [I_A_NUM_BITS-1:0] i_a;
    logic [O_A_NUM_BITS-1:0] o_a;
    logic                    o_valid;
    logic                    o_busy;
    logic                    o_logged_in;
    logic [I_U_NUM_BITS-1:0] o_user;
    logic                    o_db_req;
    logic [1:0]              o_db_op;
    logic [I_A_NUM_BITS-1:0] o_db_key;
    logic                    i_db_ack;
    logic                    i_db_ok;

    modport slave (
        input  i_rdy, i_cmd, i_u, i_a, i_db_ack, i_db_ok,
        output o_a, o_valid, o_busy, o_logged_in, o_user,
               o_db_req, o_db_op, o_db_key
    );

    modport master (
        output i_rdy, i_cmd, i_u, i_a, i_db_ack, i_db_ok,
        input  o_a, o_valid, o_busy, o_logged_in, o_user,
               o_db_req, o_db_op, o_db_key
    );
endinterface

// File: rtl/shop_cmd_ctrl.sv
// Shop command sequencer and access controller.
// Accepts one command per i_rdy strobe, keeps the user table and the login
// session, enforces admin/user privileges and forwards item operations to
// the database over a req/ack handshake with a timeout.
// Optional per-user purchase limit: define SHOP_BUY_LIMIT_EN.
module shop_cmd_ctrl #(
    parameter int                          I_A_NUM_BITS   = 24,
    parameter int                          I_U_NUM_BITS   = 4,
    parameter int                          O_A_NUM_BITS   = 24,
    parameter int                          MAX_USERS      = 5,
    parameter logic [I_A_NUM_BITS-1:0]     ADMIN_USERNAME = "Adm",
    parameter int                          TIMEOUT_CYCLES = 16
`ifdef SHOP_BUY_LIMIT_EN
    ,
    parameter int                          MAX_BUYS       = 3
`endif
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    shop_cmd_ctrl_if.slave bus
);
    localparam int SLOT_W     = (MAX_USERS > 1) ? $clog2(MAX_USERS) : 1;
    localparam int TABLE_SIZE = 1 << SLOT_W;
    localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [I_U_NUM_BITS-1:0] MAX_U    = I_U_NUM_BITS'(MAX_USERS);
    localparam logic [TMO_W-1:0]        TMO_LAST = TMO_W'(TIMEOUT_CYCLES);

    localparam logic [O_A_NUM_BITS-1:0] ST_OK  = O_A_NUM_BITS'("OK ");
    localparam logic [O_A_NUM_BITS-1:0] ST_ERR = O_A_NUM_BITS'("ERR");
    localparam logic [O_A_NUM_BITS-1:0] ST_DEN = O_A_NUM_BITS'("DEN");
    localparam logic [O_A_NUM_BITS-1:0] ST_TMO = O_A_NUM_BITS'("TMO");

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_DEL = 2'b10;
    localparam logic [1:0] OP_BUY = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT_ACK,
        RESP
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE     = 3'd0,
        CMD_LOGIN    = 3'd1,
        CMD_LOGOUT   = 3'd2,
        CMD_ADD_USR  = 3'd3,
        CMD_DEL_USR  = 3'd4,
        CMD_ADD_ITEM = 3'd5,
        CMD_DEL_ITEM = 3'd6,
        CMD_BUY      = 3'd7
    } cmd_t;

    state_t                  state;
    cmd_t                    cmd;
    logic [I_U_NUM_BITS-1:0] cmd_u;
    logic [I_A_NUM_BITS-1:0] cmd_a;
    logic [O_A_NUM_BITS-1:0] pend_status;
    logic [TMO_W-1:0]        tmo_cnt;

    logic [I_A_NUM_BITS-1:0] names [TABLE_SIZE];
    logic [TABLE_SIZE-1:0]   valid;
    logic                    logged_in;
    logic [I_U_NUM_BITS-1:0] user;

    logic [O_A_NUM_BITS-1:0] resp_a;
    logic                    resp_valid;
    logic                    busy;
    logic                    db_req;
    logic [1:0]              db_op;
    logic [I_A_NUM_BITS-1:0] db_key;

    logic [SLOT_W-1:0]       cmd_slot;
    logic [SLOT_W-1:0]       user_slot;
    logic                    u_in_range;
    logic                    is_admin;

    logic [O_A_NUM_BITS-1:0] chk_status;
    logic                    chk_issue;
    logic [1:0]              chk_op;
    logic                    chk_open;
    logic                    chk_close;
    logic                    chk_add;
    logic                    chk_del;

`ifdef SHOP_BUY_LIMIT_EN
    localparam int                      BUY_W   = $clog2(MAX_BUYS + 1);
    localparam logic [BUY_W-1:0]        BUY_MAX = BUY_W'(MAX_BUYS);
    localparam logic [O_A_NUM_BITS-1:0] ST_LIM  = O_A_NUM_BITS'("LIM");

    logic [BUY_W-1:0] buy_cnt [TABLE_SIZE];
`endif

    assign cmd_slot   = cmd_u[SLOT_W-1:0];
    assign user_slot  = user[SLOT_W-1:0];
    assign u_in_range = (cmd_u < MAX_U);
    assign is_admin   = logged_in && (user == '0);

    assign bus.o_a         = resp_a;
    assign bus.o_valid     = resp_valid;
    assign bus.o_busy      = busy;
    assign bus.o_logged_in = logged_in;
    assign bus.o_user      = user;
    assign bus.o_db_req    = db_req;
    assign bus.o_db_op     = db_op;
    assign bus.o_db_key    = db_key;

    // Privilege and table checks for the latched command, consumed in CHECK.
    always_comb begin
        chk_status = ST_ERR;
        chk_issue  = 1'b0;
        chk_op     = OP_ADD;
        chk_open   = 1'b0;
        chk_close  = 1'b0;
        chk_add    = 1'b0;
        chk_del    = 1'b0;
        case (cmd)
            CMD_LOGIN: begin
                if (logged_in) begin
                    chk_status = ST_ERR;
                end else if (!u_in_range || !valid[cmd_slot] || (names[cmd_slot] != cmd_a)) begin
                    chk_status = ST_DEN;
                end else begin
                    chk_status = ST_OK;
                    chk_open   = 1'b1;
                end
            end
            CMD_LOGOUT: begin
                if (!logged_in) begin
                    chk_status = ST_ERR;
                end else begin
                    chk_status = ST_OK;
                    chk_close  = 1'b1;
                end
            end
            CMD_ADD_USR: begin
                if (!is_admin) begin
                    chk_status = ST_DEN;
                end else if ((cmd_u == '0) || !u_in_range || valid[cmd_slot]) begin
                    chk_status = ST_ERR;
                end else begin
                    chk_status = ST_OK;
                    chk_add    = 1'b1;
                end
            end
            CMD_DEL_USR: begin
                if (!is_admin) begin
                    chk_status = ST_DEN;
                end else if ((cmd_u == '0) || !u_in_range || !valid[cmd_slot]) begin
                    chk_status = ST_ERR;
                end else begin
                    chk_status = ST_OK;
                    chk_del    = 1'b1;
                end
            end
            CMD_ADD_ITEM, CMD_DEL_ITEM: begin
                if (!is_admin) begin
                    chk_status = ST_DEN;
                end else begin
                    chk_issue = 1'b1;
                    chk_op    = (cmd == CMD_ADD_ITEM) ? OP_ADD : OP_DEL;
                end
            end
            CMD_BUY: begin
                if (!logged_in || is_admin) begin
                    chk_status = ST_DEN;
`ifdef SHOP_BUY_LIMIT_EN
                end else if (buy_cnt[user_slot] == BUY_MAX) begin
                    chk_status = ST_LIM;
`endif
                end else begin
                    chk_issue = 1'b1;
                    chk_op    = OP_BUY;
                end
            end
            default: chk_status = ST_ERR;
        endcase
    end

    // Main sequencer: command capture, table/session updates, db handshake, response.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            cmd         <= CMD_NONE;
            cmd_u       <= '0;
            cmd_a       <= '0;
            pend_status <= '0;
            tmo_cnt     <= '0;
            valid       <= TABLE_SIZE'(1);
            logged_in   <= 1'b0;
            user        <= '0;
            resp_a      <= '0;
            resp_valid  <= 1'b0;
            busy        <= 1'b0;
            db_req      <= 1'b0;
            db_op       <= '0;
            db_key      <= '0;
            for (int i = 0; i < TABLE_SIZE; i++) begin
                names[i] <= (i == 0) ? ADMIN_USERNAME : '0;
`ifdef SHOP_BUY_LIMIT_EN
                buy_cnt[i] <= '0;
`endif
            end
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_rdy) begin
                        cmd   <= cmd_t'(bus.i_cmd);
                        cmd_u <= bus.i_u;
                        cmd_a <= bus.i_a;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    pend_status <= chk_status;
                    if (chk_open) begin
                        logged_in <= 1'b1;
                        user      <= cmd_u;
                    end
                    if (chk_close) begin
                        logged_in <= 1'b0;
                        user      <= '0;
                    end
                    if (chk_add) begin
                        names[cmd_slot] <= cmd_a;
                        valid[cmd_slot] <= 1'b1;
                    end
                    if (chk_del) begin
                        valid[cmd_slot] <= 1'b0;
                    end
`ifdef SHOP_BUY_LIMIT_EN
                    if (chk_add || chk_del) begin
                        buy_cnt[cmd_slot] <= '0;
                    end
`endif
                    if (chk_issue) begin
                        db_req  <= 1'b1;
                        db_op   <= chk_op;
                        db_key  <= cmd_a;
                        tmo_cnt <= TMO_W'(1);
                        state   <= ISSUE;
                    end else begin
                        state <= RESP;
                    end
                end
                ISSUE, WAIT_ACK: begin
                    state <= WAIT_ACK;
                    if (bus.i_db_ack) begin
                        db_req      <= 1'b0;
                        pend_status <= bus.i_db_ok ? ST_OK : ST_ERR;
                        state       <= RESP;
`ifdef SHOP_BUY_LIMIT_EN
                        if ((cmd == CMD_BUY) && bus.i_db_ok && (buy_cnt[user_slot] != BUY_MAX)) begin
                            buy_cnt[user_slot] <= buy_cnt[user_slot] + 1'b1;
                        end
`endif
                    end else if (tmo_cnt == TMO_LAST) begin
                        db_req      <= 1'b0;
                        pend_status <= ST_TMO;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_a     <= pend_status;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
